// File: rtl/pipe_ctrl.sv
// pipe_ctrl: E/M/W control registers, hazard stall/flush and forwarding selects for the 5-stage core.
// Define PIPE_FORWARD_EN for forwarding; without it any in-flight writer of a D source stalls decode.
module pipe_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic       regWriteD,
    input  logic       memToRegD,
    input  logic       memReadD,
    input  logic       memWriteD,
    input  logic       aluSrcD,
    input  logic       regDstD,
    input  logic       branchD,
    input  logic [2:0] ALUControlD,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rdD,
    input  logic       ext_stall,
    output logic       regWriteE,
    output logic       regWriteM,
    output logic       regWriteW,
    output logic       memToRegE,
    output logic       memToRegM,
    output logic       memToRegW,
    output logic       memReadM,
    output logic       memWriteM,
    output logic       aluSrcE,
    output logic [2:0] ALUControlE,
    output logic [4:0] rsE,
    output logic [4:0] rtE,
    output logic [4:0] writeRegE,
    output logic [4:0] writeRegM,
    output logic [4:0] writeRegW,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE
);
    logic       memReadE, memWriteE, regDstE, branchE;
    logic [4:0] rdE;
    logic       hazard, unused_ok;

    assign writeRegE = regDstE ? rdE : rtE;

`ifdef PIPE_FORWARD_EN
    logic lwstall, brstall;
    assign forwardAE = (regWriteM && writeRegM != 5'd0 && writeRegM == rsE) ? 2'b10 :
                       (regWriteW && writeRegW != 5'd0 && writeRegW == rsE) ? 2'b01 : 2'b00;
    assign forwardBE = (regWriteM && writeRegM != 5'd0 && writeRegM == rtE) ? 2'b10 :
                       (regWriteW && writeRegW != 5'd0 && writeRegW == rtE) ? 2'b01 : 2'b00;
    assign forwardAD = regWriteM && writeRegM != 5'd0 && writeRegM == rsD;
    assign forwardBD = regWriteM && writeRegM != 5'd0 && writeRegM == rtD;
    assign lwstall   = memToRegE && (rtE == rsD || rtE == rtD);
    assign brstall   = branchD && ((regWriteE && (writeRegE == rsD || writeRegE == rtD)) ||
                                   (memToRegM && (writeRegM == rsD || writeRegM == rtD)));
    assign hazard    = lwstall || brstall;
    assign unused_ok = branchE;
`else
    // A consumer waits until every in-flight writer of its sources has retired.
    function automatic logic dep(input logic we, input logic [4:0] wr, input logic [4:0] a, input logic [4:0] b);
        return we && wr != 5'd0 && (wr == a || wr == b);
    endfunction
    assign forwardAE = 2'b00;
    assign forwardBE = 2'b00;
    assign forwardAD = 1'b0;
    assign forwardBD = 1'b0;
    assign hazard    = dep(regWriteE, writeRegE, rsD, rtD) || dep(regWriteM, writeRegM, rsD, rtD) ||
                       dep(regWriteW, writeRegW, rsD, rtD);
    assign unused_ok = branchE ^ branchD;
`endif

    assign stallF = hazard || ext_stall;
    assign stallD = hazard || ext_stall;
    assign flushE = hazard && !ext_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {regWriteE, memToRegE, memReadE, memWriteE, aluSrcE, regDstE, branchE, ALUControlE, rsE, rtE, rdE} <= '0;
            {regWriteM, memToRegM, memReadM, memWriteM, writeRegM} <= '0;
            {regWriteW, memToRegW, writeRegW} <= '0;
        end else if (!ext_stall) begin
            {regWriteE, memToRegE, memReadE, memWriteE, aluSrcE, regDstE, branchE, ALUControlE, rsE, rtE, rdE} <=
                flushE ? '0 : {regWriteD, memToRegD, memReadD, memWriteD, aluSrcD, regDstD, branchD, ALUControlD, rsD, rtD, rdD};
            {regWriteM, memToRegM, memReadM, memWriteM, writeRegM} <= {regWriteE, memToRegE, memReadE, memWriteE, writeRegE};
            {regWriteW, memToRegW, writeRegW} <= {regWriteM, memToRegM, writeRegM};
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed table plus hand-written hazard sequences for pipe_ctrl.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       regWriteD, memToRegD, memReadD, memWriteD, aluSrcD, regDstD, branchD;
    logic [2:0] ALUControlD;
    logic [4:0] rsD, rtD, rdD;
    logic       ext_stall;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, memToRegW;
    logic       memReadM, memWriteM, aluSrcE;
    logic [2:0] ALUControlE;
    logic [4:0] rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, stallF, stallD, flushE;
    int checks = 0;
    int failures = 0;

    localparam logic [6:0] ADD = 7'b1000010;
    localparam logic [6:0] LW  = 7'b1110100;
    localparam logic [6:0] SW  = 7'b0001100;
    localparam logic [6:0] BEQ = 7'b0000001;
    localparam logic [6:0] NOP = 7'b0000000;

    pipe_ctrl dut (
        .clk(clk), .resetn(resetn),
        .regWriteD(regWriteD), .memToRegD(memToRegD), .memReadD(memReadD), .memWriteD(memWriteD),
        .aluSrcD(aluSrcD), .regDstD(regDstD), .branchD(branchD), .ALUControlD(ALUControlD),
        .rsD(rsD), .rtD(rtD), .rdD(rdD), .ext_stall(ext_stall),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM), .memToRegW(memToRegW),
        .memReadM(memReadM), .memWriteM(memWriteM), .aluSrcE(aluSrcE), .ALUControlE(ALUControlE),
        .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .flushE(flushE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ctl;
        logic [2:0] alu;
        logic [4:0] rs, rt, rd;
        logic [6:0] flags;
        logic [2:0] aluE;
        logic [4:0] wE, wM, wW;
        logic       stall;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [2:0] alu, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        {regWriteD, memToRegD, memReadD, memWriteD, aluSrcD, regDstD, branchD} = ctl;
        ALUControlD = alu;
        rsD = rs;
        rtD = rt;
        rdD = rd;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        ext_stall = 1'b0;
        drive(NOP, 3'b000, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // flags = {regWriteE, regWriteM, regWriteW, memToRegW, memReadM, memWriteM, aluSrcE}
        tbl[0] = '{ADD, 3'b010, 5'd2, 5'd3,  5'd1, 7'b0000000, 3'b000, 5'd0,  5'd0,  5'd0, 1'b0};
        tbl[1] = '{ADD, 3'b010, 5'd5, 5'd6,  5'd4, 7'b1000000, 3'b010, 5'd1,  5'd0,  5'd0, 1'b0};
        tbl[2] = '{LW,  3'b010, 5'd8, 5'd7,  5'd0, 7'b1100000, 3'b010, 5'd4,  5'd1,  5'd0, 1'b0};
        tbl[3] = '{SW,  3'b010, 5'd9, 5'd10, 5'd0, 7'b1110001, 3'b010, 5'd7,  5'd4,  5'd1, 1'b0};
        tbl[4] = '{NOP, 3'b000, 5'd0, 5'd0,  5'd0, 7'b0110101, 3'b010, 5'd10, 5'd7,  5'd4, 1'b0};
        tbl[5] = '{NOP, 3'b000, 5'd0, 5'd0,  5'd0, 7'b0011010, 3'b000, 5'd0,  5'd10, 5'd7, 1'b0};

        // reset holds everything at zero even with live D controls
        ext_stall = 1'b0;
        drive(7'b1000000, 3'b010, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst regWriteE", regWriteE, 0);
        chk("rst ALUControlE", ALUControlE, 0);
        chk("rst regWriteW", regWriteW, 0);
        chk("rst writeRegM", writeRegM, 0);
        chk("rst stallF", stallF, 0);
        chk("rst forwardAE", forwardAE, 0);
        resetn = 1'b1;
        cyc();
        @(negedge clk);
        chk("rel regWriteE", regWriteE, 1);
        chk("rel ALUControlE", ALUControlE, 3'b010);
        chk("rel regWriteW early", regWriteW, 0);
        cyc();
        cyc();
        @(negedge clk);
        chk("rel regWriteW 3 edges", regWriteW, 1);

        // independent instruction stream
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].ctl, tbl[i].alu, tbl[i].rs, tbl[i].rt, tbl[i].rd);
            @(negedge clk);
            chk($sformatf("vec%0d flags", i), {regWriteE, regWriteM, regWriteW, memToRegW, memReadM, memWriteM, aluSrcE}, tbl[i].flags);
            chk($sformatf("vec%0d ALUControlE", i), ALUControlE, tbl[i].aluE);
            chk($sformatf("vec%0d writeRegE", i), writeRegE, tbl[i].wE);
            chk($sformatf("vec%0d writeRegM", i), writeRegM, tbl[i].wM);
            chk($sformatf("vec%0d writeRegW", i), writeRegW, tbl[i].wW);
            chk($sformatf("vec%0d stallF", i), stallF, tbl[i].stall);
            chk($sformatf("vec%0d flushE", i), flushE, tbl[i].stall);
            chk($sformatf("vec%0d forwardAE", i), forwardAE, 0);
            cyc();
        end

        // add $3 followed by a consumer of $3
        do_reset();
        drive(ADD, 3'b010, 5'd1, 5'd2, 5'd3);
        cyc();
        drive(ADD, 3'b110, 5'd3, 5'd0, 5'd6);
`ifdef PIPE_FORWARD_EN
        @(negedge clk);
        chk("fwd no stall", stallF, 0);
        cyc();
        drive(ADD, 3'b001, 5'd3, 5'd0, 5'd7);
        @(negedge clk);
        chk("fwd AE from M", forwardAE, 2'b10);
        chk("fwd BE none", forwardBE, 2'b00);
        cyc();
        drive(ADD, 3'b010, 5'd1, 5'd2, 5'd0);
        @(negedge clk);
        chk("fwd AE from W", forwardAE, 2'b01);
        cyc();
        drive(ADD, 3'b010, 5'd0, 5'd0, 5'd8);
        cyc();
        @(negedge clk);
        chk("fwd AE zero reg", forwardAE, 2'b00);
`else
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nofwd forwardAE", forwardAE, 2'b00);
            if (!stallF) break;
            n++;
            cyc();
        end
        chk("nofwd stall cycles", n, 3);
        cyc();
        @(negedge clk);
        chk("nofwd sub in E rsE", rsE, 3);
        chk("nofwd sub forwardAE", forwardAE, 2'b00);
`endif

        // load-use
        do_reset();
        drive(LW, 3'b010, 5'd1, 5'd5, 5'd0);
        cyc();
        drive(ADD, 3'b010, 5'd5, 5'd0, 5'd9);
        @(negedge clk);
        chk("lu stallF", stallF, 1);
        chk("lu stallD", stallD, 1);
        chk("lu flushE", flushE, 1);
        cyc();
        @(negedge clk);
        chk("lu bubble regWriteE", regWriteE, 0);
        chk("lu bubble memToRegE", memToRegE, 0);
        chk("lu bubble ALUControlE", ALUControlE, 0);
        chk("lu bubble writeRegE", writeRegE, 0);
        chk("lu lw in M", writeRegM, 5);
`ifdef PIPE_FORWARD_EN
        chk("lu stall released", stallF, 0);
`else
        chk("lu stall held", stallF, 1);
`endif

        // branch on an ALU producer
        do_reset();
        drive(ADD, 3'b010, 5'd1, 5'd2, 5'd4);
        cyc();
        drive(BEQ, 3'b110, 5'd4, 5'd0, 5'd0);
        @(negedge clk);
        chk("br stallF", stallF, 1);
        chk("br flushE", flushE, 1);
        chk("br forwardAD early", forwardAD, 0);
        cyc();
        @(negedge clk);
`ifdef PIPE_FORWARD_EN
        chk("br stall released", stallF, 0);
        chk("br forwardAD", forwardAD, 1);
`else
        chk("br stall held", stallF, 1);
        chk("br forwardAD tied", forwardAD, 0);
`endif

        // ext_stall over a load-use
        do_reset();
        drive(ADD, 3'b010, 5'd12, 5'd13, 5'd11);
        cyc();
        drive(LW, 3'b010, 5'd1, 5'd5, 5'd0);
        cyc();
        drive(ADD, 3'b010, 5'd5, 5'd0, 5'd9);
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("xs%0d flushE", i), flushE, 0);
            chk($sformatf("xs%0d stallF", i), stallF, 1);
            chk($sformatf("xs%0d E", i), {regWriteE, writeRegE}, {1'b1, 5'd5});
            chk($sformatf("xs%0d M", i), {regWriteM, writeRegM}, {1'b1, 5'd11});
            chk($sformatf("xs%0d W", i), {regWriteW, writeRegW}, 0);
            cyc();
        end
        ext_stall = 1'b0;
        @(negedge clk);
        chk("xs release flushE", flushE, 1);
        cyc();
        @(negedge clk);
        chk("xs bubble regWriteE", regWriteE, 0);
        chk("xs writeRegM", writeRegM, 5);
        chk("xs writeRegW", writeRegW, 11);

        // asynchronous reset during a freeze
        ext_stall = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("mid rst regWriteM", regWriteM, 0);
        chk("mid rst writeRegM", writeRegM, 0);
        chk("mid rst writeRegW", writeRegW, 0);
        chk("mid rst stallF ext", stallF, 1);
        ext_stall = 1'b0;
        #1;
        chk("mid rst stallF", stallF, 0);
        chk("mid rst flushE", flushE, 0);
        resetn = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

- Carries the decode-stage control word of the five-stage MIPS core through the Execute, Memory and Writeback pipeline registers.
- Detects data hazards and generates forwarding selects plus stall/flush for the fetch/decode/execute registers.
- Sits between the decode-stage controller outputs and the datapath.
- Owns the only sequential state of the control path.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- regWriteD, memToRegD, memReadD, memWriteD, aluSrcD, regDstD, branchD  in  1 each  decoded controls, decode stage
- ALUControlD  in  3  ALU operation, decode stage
- rsD, rtD, rdD  in  5 each  register fields of the decode-stage instruction
- ext_stall  in  1  memory not ready; freeze the whole pipeline
- regWriteE/M/W, memToRegE/M/W  out  1 each  stage-qualified controls
- memReadM, memWriteM  out  1 each  memory-stage controls
- aluSrcE  out  1  execute-stage ALU operand select
- ALUControlE  out  3  execute-stage ALU operation
- rsE, rtE  out  5 each  execute-stage source registers
- writeRegE, writeRegM, writeRegW  out  5 each  destination register per stage
- forwardAE, forwardBE  out  2 each  ALU operand forward select: 00 regfile, 01 from W, 10 from M
- forwardAD, forwardBD  out  1 each  branch comparator forward from M
- stallF, stallD  out  1 each  hold PC / hold IF-ID register
- flushE  out  1  clear ID-EX register (insert bubble)

## Operation
- Stage registers:
  - E register holds all D controls plus rsD, rtD, rdD.
  - M register holds regWrite, memToReg, memRead, memWrite, writeRegE.
  - W register holds regWrite, memToReg, writeRegM.
- writeRegE = regDstE ? rdE : rtE, combinational from the E register.
- Forwarding (writeReg of 0 never forwards):
  - forwardAE = 10 if regWriteM && writeRegM!=0 && writeRegM==rsE.
  - Else forwardAE = 01 if regWriteW && writeRegW!=0 && writeRegW==rsE.
  - Else forwardAE = 00.
  - forwardBE: same rules against rtE.
  - forwardAD = regWriteM && writeRegM!=0 && writeRegM==rsD; forwardBD likewise with rtD.
- lwstall = memToRegE && (rtE==rsD || rtE==rtD).
- brstall = branchD && ((regWriteE && writeRegE∈{rsD,rtD}) || (memToRegM && writeRegM∈{rsD,rtD})).
- hazard = lwstall || brstall.
  - stallF = stallD = hazard || ext_stall.
  - flushE = hazard && !ext_stall.
- Register update each edge, in priority order:
  - ext_stall=1: E, M, W all hold; no bubble.
  - flushE=1: E loads all zeros (bubble); M, W advance.
  - Otherwise: E←D, M←E, W←M.
- Two-state implicit control per cycle: RUN (advance) / FROZEN (ext_stall). Hazard stall is RUN with a bubble in E. A bubble is all-zero controls, i.e. a no-write nop.
- Simultaneous ext_stall and hazard: ext_stall wins; the hazard is re-evaluated when ext_stall drops.

## Timing
- resetn low, asynchronous: all E/M/W register bits are 0. Consequences:
  - Every registered output is 0; writeReg* = 0.
  - forward* = 0; stallF = stallD = flushE = 0, unless driven by D inputs or ext_stall.
- Release is synchronous in effect: first capture at the first rising edge with resetn high.
- Latency: a D control appears on E outputs 1 cycle later, M after 2, W after 3, absent stalls.
- Forward, stall and flush outputs are combinational in the same cycle as their inputs; no registered lag.
- Load-use costs exactly 1 bubble.
- brstall on an ALU producer in E costs 1 cycle; on a load in M it costs 1 cycle.
- Reset asserted mid-stall clears the pipeline immediately; no pending stall survives.

## Configuration
- PIPE_FORWARD_EN defined: forwarding and hazard logic exactly as above.
- Not defined:
  - forwardAE/BE/AD/BD tie to 0.
  - hazard = any of E, M, W with regWrite && writeReg!=0 && writeReg∈{rsD,rtD}.
  - Stall/flush/priority rules unchanged.

## Test plan
- Reset: hold resetn=0 with D inputs set to regWriteD=1, ALUControlD=3'b010 → all E/M/W outputs 0. Release and apply 3 edges → regWriteW=1.
- Forward: add $3 in E/M, then sub rs=$3 in E; regWriteM=1, writeRegM=3, rsE=3 → forwardAE=10. One cycle later, with W writing $3 → 01. With writeReg=0 → 00.
- Load-use: lw rt=5 in E (memToRegE=1, rtE=5), rsD=5 → stallF=stallD=flushE=1. Next cycle E controls all 0 and stalls deassert.
- Branch: branchD=1, rsD=4, add writing $4 in E → brstall asserted 1 cycle. Next cycle forwardAD=1.
- ext_stall held 3 cycles during a load-use → flushE=0 and E/M/W unchanged for 3 cycles. Bubble inserted on the first edge after release.
- Build without PIPE_FORWARD_EN: the add→sub $3 sequence stalls 3 cycles and forwardAE stays 00.
